cp0_exc_ctrl: RTL
=================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port m_valid, input, 1 bit: the M-stage slot holds a real instruction (not a bubble).
REQ-004 SHALL have port m_pc, input, 32 bits: PC of the M-stage instruction.
REQ-005 SHALL have port m_exc, input, 5 bits ([6:2]): the final M-stage exception code; 0 means none; other legal values are 4, 5, 10, 12.
REQ-006 SHALL have port m_bd, input, 1 bit: the M-stage instruction sits in a branch delay slot.
REQ-007 SHALL have port hwint, input, 6 bits ([7:2]): level-sensitive hardware interrupt lines.
REQ-008 SHALL have port cp0_we, input, 1 bit: mtc0 write enable, M stage.
REQ-009 SHALL have port cp0_addr, input, 5 bits: CP0 register number used for mtc0 and mfc0.
REQ-010 SHALL have port cp0_wdata, input, 32 bits: mtc0 write data.
REQ-011 SHALL have port m_eret, input, 1 bit: eret is in the M stage.
REQ-012 SHALL have port cp0_rdata, output, 32 bits: mfc0 read data, combinational.
REQ-013 SHALL have port epc_out, output, 32 bits: current EPC value, the eret return target.
REQ-014 SHALL have port int_req, output, 1 bit: take exception/interrupt now; the pipeline flushes and fetch redirects to 0x0000_4180.
REQ-015 SHALL have port exl_out, output, 1 bit: current SR.EXL.

Function
REQ-016 SHALL implement SR (reg 12) with fields IM[15:10], EXL[1] and IE[0]; all other bits read 0.
REQ-017 SHALL implement Cause (reg 13) with fields BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0.
REQ-018 SHALL implement EPC (reg 14) as 32 bits with bits [1:0] always 0.
REQ-019 SHALL make PrID (reg 15) read constant 32'h2018_1215.
REQ-020 SHALL make any other cp0_addr read 0 and ignore writes to it.
REQ-021 SHALL load Cause.IP with hwint every cycle, regardless of IM, IE or EXL.
REQ-022 SHALL decode int_pend = |(hwint & SR.IM) && SR.IE && !SR.EXL.
REQ-023 SHALL decode exc_pend = (m_exc != 0) && !SR.EXL && m_valid.
REQ-024 SHALL drive int_req = (int_pend && m_valid) || exc_pend, combinationally, in the same cycle.
REQ-025 SHALL hold an interrupt (int_pend && !m_valid) pending, with int_req low, until a valid M-stage slot appears; no interrupt is ever lost while the hwint level is held.
REQ-026 SHALL perform the entry actions at the clock edge where int_req=1, exactly once, with 1-cycle latency to exl_out=1:
- EXL <= 1;
- Cause.BD <= m_bd;
- EPC <= m_bd ? {m_pc[31:2],2'b00} - 4 : {m_pc[31:2],2'b00};
- Cause.ExcCode <= int_pend ? 0 : m_exc.
REQ-027 SHALL give interrupts priority over synchronous exceptions when both are pending in the same cycle: ExcCode=0 and EPC taken from m_pc.
REQ-028 SHALL, when m_eret=1 and int_req=0, clear EXL at the edge; epc_out is valid in that same cycle for the fetch redirect.
REQ-029 SHALL, when m_eret=1 and int_req=1 in the same cycle, let entry win and leave EXL at 1.
REQ-030 SHALL apply cp0_we only when int_req=0; the write is visible in cp0_rdata the next cycle.
REQ-031 SHALL give entry priority over mtc0 when int_req=1 and cp0_we=1 in the same cycle: the mtc0 is discarded.
REQ-032 SHALL make mtc0 to Cause write nothing, since IP, BD and ExcCode are read-only.
REQ-033 SHALL make mtc0 to EPC store {cp0_wdata[31:2],2'b00}.
REQ-034 SHALL block nested entry while EXL=1: int_req stays 0 whatever the values of hwint and m_exc.
REQ-035 SHALL produce EPC wrap-around on BD with m_pc=0 as 32'hFFFF_FFFC, from modulo-2^32 subtraction.

Reset
REQ-036 SHALL, on reset=1 and asynchronously, force SR=0, Cause=0, EPC=0; therefore int_req=0 and exl_out=0.
REQ-037 SHALL, on reset asserted mid-handler with EXL=1, clear EXL immediately, before the next edge.
REQ-038 SHALL, after reset deasserts, take no entry until software sets IE and IM, except for synchronous exceptions.

Verification
REQ-039 SHALL be checked with: SR=0x0000_0401, hwint=6'b000001, m_valid=1, m_pc=0x3010 -> int_req=1; next cycle EPC=0x3010, ExcCode=0, EXL=1.
REQ-040 SHALL be checked with: m_exc=12, m_bd=1, m_pc=0x3020, EXL=0 -> int_req=1; next cycle EPC=0x301C, Cause=0x8000_0030.
REQ-041 SHALL be checked with: EXL=1, m_exc=10, hwint all high -> int_req=0 and all registers unchanged; then m_eret=1 -> EXL=0 next cycle, epc_out unchanged.
REQ-042 SHALL be checked with: int_pend=1 for 3 cycles with m_valid=0, then m_valid=1, m_pc=0x3040 -> int_req=1 only in the m_valid=1 cycle; EPC=0x3040.
REQ-043 SHALL be checked with: cp0_we=1, cp0_addr=12, cp0_wdata=0xFFFF_FFFF together with m_exc=4 -> SR keeps its old IM/IE, EXL=1, ExcCode=4.
REQ-044 SHALL be checked with: reset pulsed while EXL=1 and EPC=0x3000 -> exl_out=0 and EPC=0 before the next clk edge; cp0_rdata at addr 15 = 0x2018_1215.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 status/cause/epc registers with exception and interrupt entry control
module cp0_exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [6:2]  m_exc,
    input  logic        m_bd,
    input  logic [7:2]  hwint,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        m_eret,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        int_req,
    output logic        exl_out
);
    logic [5:0]  im;
    logic [5:0]  ip;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_al;
    logic [31:0] epc_ent;

    assign int_pend = |(hwint & im) && ie && !exl;
    assign exc_pend = (m_exc != 5'd0) && !exl && m_valid;
    assign int_req  = (int_pend && m_valid) || exc_pend;
    assign pc_al    = m_pc & 32'hFFFF_FFFC;
    assign epc_ent  = pc_al - {29'd0, m_bd, 2'b00};
    assign epc_out  = epc;
    assign exl_out  = exl;

    // register update: entry beats eret and mtc0; eret clears EXL after any SR write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hwint;
            if (int_req) begin
                exl      <= 1'b1;
                bd       <= m_bd;
                epc      <= epc_ent;
                exc_code <= int_pend ? 5'd0 : m_exc;
            end else begin
                if (cp0_we && cp0_addr == 5'd12) begin
                    im  <= cp0_wdata[15:10];
                    exl <= cp0_wdata[1];
                    ie  <= cp0_wdata[0];
                end
                if (cp0_we && cp0_addr == 5'd14)
                    epc <= cp0_wdata & 32'hFFFF_FFFC;
                if (m_eret)
                    exl <= 1'b0;
            end
        end
    end

    // mfc0 read mux
    always_comb begin
        cp0_rdata = (cp0_addr == 5'd12) ? {16'd0, im, 8'd0, exl, ie} :
                    (cp0_addr == 5'd13) ? {bd, 15'd0, ip, 3'd0, exc_code, 2'b00} :
                    (cp0_addr == 5'd14) ? epc :
                    (cp0_addr == 5'd15) ? 32'h2018_1215 : 32'd0;
    end
endmodule
